// File: rtl/gbe_udp_packetizer_if.sv
// Application TX bus between the packetizer and the GbE UDP core.
// The master drives payload bytes and addressing; the core returns FIFO status.
interface gbe_udp_packetizer_if;
  logic [7:0]  app_tx_data;
  logic        app_tx_dvld;
  logic        app_tx_eof;
  logic [31:0] app_tx_destip;
  logic [15:0] app_tx_destport;
  logic        app_tx_afull;
  logic        app_tx_overflow;

  modport master (
    output app_tx_data, app_tx_dvld, app_tx_eof, app_tx_destip, app_tx_destport,
    input  app_tx_afull, app_tx_overflow
  );

  modport slave (
    input  app_tx_data, app_tx_dvld, app_tx_eof, app_tx_destip, app_tx_destport,
    output app_tx_afull, app_tx_overflow
  );
endinterface

// File: rtl/gbe_udp_packetizer.sv
// Packs 32-bit samples into UDP payloads: 8-byte header (seq, word count)
// followed by N words, one byte per cycle, throttled by the core's afull.
module gbe_udp_packetizer #(
  parameter logic [31:0] DEFAULT_DESTIP   = 32'h0,
  parameter logic [15:0] DEFAULT_DESTPORT = 16'h0,
  parameter int unsigned MAX_WORDS        = 366
) (
  input  logic                         app_clk,
  input  logic                         app_rst_n,
  input  logic                         cfg_enable,
  input  logic [31:0]                  cfg_destip,
  input  logic [15:0]                  cfg_destport,
  input  logic [8:0]                   cfg_payload_words,
  input  logic [31:0]                  data_in,
  input  logic                         data_vld,
  output logic                         data_rdy,
  gbe_udp_packetizer_if.master         tx,
  output logic [31:0]                  pkt_cnt,
  output logic [15:0]                  ovf_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_HDR, S_PAYLOAD, S_GAP} state_t;

  localparam logic [8:0] MAX_N = 9'(MAX_WORDS);

  state_t      r_state, w_state_nxt;
  logic [31:0] r_hold;
  logic        r_hold_full;
  logic        r_rdy_en;
  logic [31:0] r_seq;
  logic [8:0]  r_n;
  logic [8:0]  r_words_left;
  logic [2:0]  r_hdr_idx;
  logic [1:0]  r_byte_idx;
  logic        r_gap;
  logic [7:0]  r_tx_data;
  logic        r_tx_dvld;
  logic        r_tx_eof;
  logic [31:0] r_tx_destip;
  logic [15:0] r_tx_destport;
  logic [31:0] r_pkt_cnt;
  logic [15:0] r_ovf_cnt;

  logic        w_start, w_emit, w_eof, w_word_done, w_load, w_allow;
  logic [7:0]  w_byte;
  logic [8:0]  w_n_clamp;
  logic [63:0] w_hdr;
  logic [5:0]  w_hdr_sh;
  logic [4:0]  w_pay_sh;

  assign w_hdr    = {r_seq, 23'd0, r_n};
  assign w_hdr_sh = {~r_hdr_idx, 3'b000};
  assign w_pay_sh = {~r_byte_idx, 3'b000};

  always_comb begin
    w_n_clamp = cfg_payload_words;
    if (cfg_payload_words == 9'd0)
      w_n_clamp = 9'd1;
    else if (cfg_payload_words > MAX_N)
      w_n_clamp = MAX_N;
  end

  // The IDLE->HDR edge already emits header byte 0 so back-to-back packets
  // show exactly two idle bus cycles after eof (the two GAP cycles).
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_emit      = 1'b0;
    w_eof       = 1'b0;
    w_word_done = 1'b0;
    w_byte      = r_seq[31:24];
    case (r_state)
      S_IDLE: begin
        if (cfg_enable && r_hold_full) begin
          w_start     = 1'b1;
          w_emit      = !tx.app_tx_afull;
          w_state_nxt = S_HDR;
        end
      end
      S_HDR: begin
        w_emit = !tx.app_tx_afull;
        w_byte = w_hdr[w_hdr_sh +: 8];
        if (w_emit && r_hdr_idx == 3'd7)
          w_state_nxt = S_PAYLOAD;
      end
      S_PAYLOAD: begin
        w_emit      = !tx.app_tx_afull && r_hold_full;
        w_byte      = r_hold[w_pay_sh +: 8];
        w_word_done = w_emit && (r_byte_idx == 2'd3);
        if (w_word_done && r_words_left == 9'd1) begin
          w_eof       = 1'b1;
          w_state_nxt = S_GAP;
        end
      end
      S_GAP: begin
        if (r_gap)
          w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_allow  = r_rdy_en && (r_state != S_GAP) && !(r_state == S_IDLE && !cfg_enable);
    data_rdy = w_allow && (!r_hold_full || w_word_done);
    w_load   = data_vld && data_rdy;
  end

  always_ff @(posedge app_clk or negedge app_rst_n) begin
    if (!app_rst_n)
      r_state <= S_IDLE;
    else
      r_state <= w_state_nxt;
  end

  always_ff @(posedge app_clk or negedge app_rst_n) begin
    if (!app_rst_n) begin
      r_hold        <= '0;
      r_hold_full   <= 1'b0;
      r_rdy_en      <= 1'b0;
      r_seq         <= '0;
      r_n           <= 9'd1;
      r_words_left  <= 9'd1;
      r_hdr_idx     <= '0;
      r_byte_idx    <= '0;
      r_gap         <= 1'b0;
      r_tx_data     <= '0;
      r_tx_dvld     <= 1'b0;
      r_tx_eof      <= 1'b0;
      r_tx_destip   <= DEFAULT_DESTIP;
      r_tx_destport <= DEFAULT_DESTPORT;
      r_pkt_cnt     <= '0;
      r_ovf_cnt     <= '0;
    end else begin
      r_rdy_en <= 1'b1;

      if (w_load) begin
        r_hold      <= data_in;
        r_hold_full <= 1'b1;
      end else if (w_word_done) begin
        r_hold_full <= 1'b0;
      end

      if (w_start) begin
        r_tx_destip   <= cfg_destip;
        r_tx_destport <= cfg_destport;
        r_n           <= w_n_clamp;
        r_words_left  <= w_n_clamp;
        r_hdr_idx     <= w_emit ? 3'd1 : 3'd0;
        r_byte_idx    <= '0;
      end else if (r_state == S_HDR && w_emit) begin
        r_hdr_idx <= r_hdr_idx + 3'd1;
      end

      if (r_state == S_PAYLOAD && w_emit) begin
        r_byte_idx <= r_byte_idx + 2'd1;
        if (w_word_done)
          r_words_left <= r_words_left - 9'd1;
      end

      r_gap <= (r_state == S_GAP) ? ~r_gap : 1'b0;

      r_tx_dvld <= w_emit;
      r_tx_eof  <= w_eof;
      if (w_emit)
        r_tx_data <= w_byte;

      if (w_eof) begin
        r_seq     <= r_seq + 32'd1;
        r_pkt_cnt <= r_pkt_cnt + 32'd1;
      end

      if (tx.app_tx_overflow && r_ovf_cnt != 16'hFFFF)
        r_ovf_cnt <= r_ovf_cnt + 16'd1;
    end
  end

  assign tx.app_tx_data     = r_tx_data;
  assign tx.app_tx_dvld     = r_tx_dvld;
  assign tx.app_tx_eof      = r_tx_eof;
  assign tx.app_tx_destip   = r_tx_destip;
  assign tx.app_tx_destport = r_tx_destport;
  assign pkt_cnt            = r_pkt_cnt;
  assign ovf_cnt            = r_ovf_cnt;

endmodule

// File: tb/tb_gbe_udp_packetizer.sv
// Scoreboard bench for gbe_udp_packetizer: expected bytes are queued as
// samples are driven and popped as the DUT emits them on the TX bus.
module tb_gbe_udp_packetizer;

  localparam logic [31:0] DEF_IP   = 32'hC0A8_0001;
  localparam logic [15:0] DEF_PORT = 16'h1234;

  typedef struct {
    logic [7:0]  d;
    logic        eof;
    logic [31:0] ip;
    logic [15:0] port;
    int unsigned len;
  } exp_t;

  logic        app_clk = 1'b0;
  logic        app_rst_n;
  logic        cfg_enable;
  logic [31:0] cfg_destip;
  logic [15:0] cfg_destport;
  logic [8:0]  cfg_payload_words;
  logic [31:0] data_in;
  logic        data_vld;
  logic        data_rdy;
  logic [31:0] pkt_cnt;
  logic [15:0] ovf_cnt;

  gbe_udp_packetizer_if tx_if ();

  gbe_udp_packetizer #(
    .DEFAULT_DESTIP  (DEF_IP),
    .DEFAULT_DESTPORT(DEF_PORT),
    .MAX_WORDS       (366)
  ) dut (
    .app_clk          (app_clk),
    .app_rst_n        (app_rst_n),
    .cfg_enable       (cfg_enable),
    .cfg_destip       (cfg_destip),
    .cfg_destport     (cfg_destport),
    .cfg_payload_words(cfg_payload_words),
    .data_in          (data_in),
    .data_vld         (data_vld),
    .data_rdy         (data_rdy),
    .tx               (tx_if),
    .pkt_cnt          (pkt_cnt),
    .ovf_cnt          (ovf_cnt)
  );

  always #5 app_clk = ~app_clk;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  exp_t        sb[$];
  logic [31:0] exp_seq = '0;
  logic [31:0] exp_pkt = '0;
  int unsigned cyc = 0;
  int unsigned mon_bytes = 0;
  int unsigned sop_cyc = 0;
  int unsigned eof_cyc = 0;
  bit          have_eof = 1'b0;
  bit          chk_contig = 1'b0;
  bit          chk_gap = 1'b0;

  task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  always @(posedge app_clk) cyc++;

  always @(negedge app_clk) begin
    if (app_rst_n) begin
      if (!tx_if.app_tx_dvld) begin
        chk_eq("eof_without_dvld", 64'(tx_if.app_tx_eof), 64'd0);
      end else begin
        chk_eq("sb_nonempty", 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
          exp_t e;
          e = sb.pop_front();
          chk_eq("byte", 64'(tx_if.app_tx_data), 64'(e.d));
          chk_eq("eof", 64'(tx_if.app_tx_eof), 64'(e.eof));
          chk_eq("destip", 64'(tx_if.app_tx_destip), 64'(e.ip));
          chk_eq("destport", 64'(tx_if.app_tx_destport), 64'(e.port));
          if (mon_bytes == 0) begin
            sop_cyc = cyc;
            if (chk_gap && have_eof)
              chk_eq("gap_cycles", 64'(cyc - eof_cyc - 1), 64'd2);
          end
          mon_bytes++;
          if (e.eof) begin
            chk_eq("pkt_len", 64'(mon_bytes), 64'(e.len));
            if (chk_contig)
              chk_eq("contiguous", 64'(cyc - sop_cyc + 1), 64'(e.len));
            eof_cyc   = cyc;
            have_eof  = 1'b1;
            mon_bytes = 0;
          end
        end
      end
    end
  end

  task automatic send_word(input logic [31:0] w);
    bit ok;
    ok = 1'b0;
    data_in  = w;
    data_vld = 1'b1;
    for (int i = 0; i < 5000 && !ok; i++) begin
      @(negedge app_clk);
      if (data_rdy) begin
        ok = 1'b1;
        @(posedge app_clk);
        #1;
      end
    end
    data_vld = 1'b0;
    chk_eq("word_accepted", 64'(ok), 64'd1);
  endtask

  task automatic push_byte(input logic [7:0] d, input logic eof, input int unsigned len);
    exp_t e;
    e.d    = d;
    e.eof  = eof;
    e.ip   = cfg_destip;
    e.port = cfg_destport;
    e.len  = len;
    sb.push_back(e);
  endtask

  task automatic send_pkt(input int unsigned cfg_n, input int unsigned n, input bit fixed);
    logic [63:0] hdr;
    logic [31:0] w;
    int unsigned len;
    len = 8 + 4 * n;
    cfg_payload_words = 9'(cfg_n);
    hdr = {exp_seq, 32'(n)};
    for (int b = 0; b < 8; b++)
      push_byte(hdr[8*(7-b) +: 8], 1'b0, len);
    for (int unsigned i = 0; i < n; i++) begin
      if (fixed)
        w = (i == 0) ? 32'hAABB_CCDD : 32'h1122_3344;
      else
        w = $urandom;
      for (int b = 0; b < 4; b++)
        push_byte(w[8*(3-b) +: 8], (i == n - 1) && (b == 3), len);
      send_word(w);
    end
    exp_seq = exp_seq + 32'd1;
    exp_pkt = exp_pkt + 32'd1;
    @(posedge app_clk);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 5000 && sb.size() != 0; i++)
      @(posedge app_clk);
    chk_eq("drain", 64'(sb.size()), 64'd0);
    @(posedge app_clk);
    #1;
  endtask

  initial begin
    app_rst_n         = 1'b0;
    cfg_enable        = 1'b1;
    cfg_destip        = 32'h0A00_0002;
    cfg_destport      = 16'h5678;
    cfg_payload_words = 9'd2;
    data_in           = '0;
    data_vld          = 1'b0;
    tx_if.app_tx_afull    = 1'b0;
    tx_if.app_tx_overflow = 1'b0;

    repeat (3) @(posedge app_clk);
    #1;
    chk_eq("rst_dvld", 64'(tx_if.app_tx_dvld), 64'd0);
    chk_eq("rst_eof", 64'(tx_if.app_tx_eof), 64'd0);
    chk_eq("rst_data", 64'(tx_if.app_tx_data), 64'd0);
    chk_eq("rst_destip", 64'(tx_if.app_tx_destip), 64'(DEF_IP));
    chk_eq("rst_destport", 64'(tx_if.app_tx_destport), 64'(DEF_PORT));
    chk_eq("rst_pkt_cnt", 64'(pkt_cnt), 64'd0);
    chk_eq("rst_ovf_cnt", 64'(ovf_cnt), 64'd0);
    chk_eq("rst_data_rdy", 64'(data_rdy), 64'd0);
    app_rst_n = 1'b1;
    #1;
    chk_eq("rdy_before_edge", 64'(data_rdy), 64'd0);
    @(posedge app_clk);
    #1;
    chk_eq("rdy_after_edge", 64'(data_rdy), 64'd1);

    // Basic N=2 packet
    chk_contig = 1'b1;
    send_pkt(2, 2, 1'b1);
    drain();
    chk_eq("pkt_cnt_1", 64'(pkt_cnt), 64'(exp_pkt));

    // afull held 5 cycles mid-header
    chk_contig = 1'b0;
    fork
      send_pkt(2, 2, 1'b1);
      begin
        for (int g = 0; g < 200 && mon_bytes < 3; g++)
          @(posedge app_clk);
        #1;
        tx_if.app_tx_afull = 1'b1;
        @(negedge app_clk);
        chk_eq("afull_lag", 64'(tx_if.app_tx_dvld), 64'd1);
        repeat (5) begin
          @(negedge app_clk);
          chk_eq("afull_hold", 64'(tx_if.app_tx_dvld), 64'd0);
        end
        tx_if.app_tx_afull = 1'b0;
        @(negedge app_clk);
        chk_eq("afull_resume", 64'(tx_if.app_tx_dvld), 64'd1);
      end
    join
    drain();
    chk_eq("pkt_cnt_2", 64'(pkt_cnt), 64'(exp_pkt));

    // Word-count clamps
    chk_contig = 1'b1;
    send_pkt(0, 1, 1'b0);
    drain();
    send_pkt(400, 366, 1'b0);
    drain();
    chk_eq("pkt_cnt_4", 64'(pkt_cnt), 64'(exp_pkt));

    // Back-to-back packets; destination change lands mid-packet
    have_eof = 1'b0;
    chk_gap  = 1'b1;
    send_pkt(3, 3, 1'b0);
    send_pkt(2, 2, 1'b0);
    cfg_destip   = 32'h0A00_0099;
    cfg_destport = 16'h9ABC;
    send_pkt(4, 4, 1'b0);
    drain();
    chk_gap = 1'b0;
    chk_eq("pkt_cnt_7", 64'(pkt_cnt), 64'(exp_pkt));

    // Reset during payload byte 5
    send_pkt(2, 2, 1'b1);
    for (int g = 0; g < 200 && mon_bytes < 12; g++)
      @(posedge app_clk);
    #2;
    app_rst_n = 1'b0;
    #1;
    chk_eq("mid_rst_dvld", 64'(tx_if.app_tx_dvld), 64'd0);
    chk_eq("mid_rst_eof", 64'(tx_if.app_tx_eof), 64'd0);
    chk_eq("mid_rst_data", 64'(tx_if.app_tx_data), 64'd0);
    chk_eq("mid_rst_destip", 64'(tx_if.app_tx_destip), 64'(DEF_IP));
    chk_eq("mid_rst_destport", 64'(tx_if.app_tx_destport), 64'(DEF_PORT));
    chk_eq("mid_rst_pkt_cnt", 64'(pkt_cnt), 64'd0);
    chk_eq("mid_rst_rdy", 64'(data_rdy), 64'd0);
    sb.delete();
    mon_bytes = 0;
    exp_seq   = '0;
    exp_pkt   = '0;
    repeat (2) @(posedge app_clk);
    #2;
    app_rst_n = 1'b1;
    #1;
    chk_eq("rel_rdy", 64'(data_rdy), 64'd0);
    send_pkt(2, 2, 1'b0);
    drain();
    chk_eq("pkt_cnt_after_rst", 64'(pkt_cnt), 64'(exp_pkt));

    // Overflow counting and saturation
    repeat (3) begin
      tx_if.app_tx_overflow = 1'b1;
      @(posedge app_clk);
      #1;
      tx_if.app_tx_overflow = 1'b0;
      @(posedge app_clk);
      #1;
    end
    chk_eq("ovf_3", 64'(ovf_cnt), 64'd3);
    tx_if.app_tx_overflow = 1'b1;
    repeat (65531) @(posedge app_clk);
    #1;
    chk_eq("ovf_fffe", 64'(ovf_cnt), 64'hFFFE);
    repeat (70000 - 65531) @(posedge app_clk);
    #1;
    tx_if.app_tx_overflow = 1'b0;
    chk_eq("ovf_sat", 64'(ovf_cnt), 64'hFFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
